fnn_layer_seq: RTL and testbench

- Per-layer sequencer for the fully connected network.
- Accepts the previous layer's activations as a valid/ready stream and broadcasts them, one per beat, to every neuron of its layer.
- Waits for all neurons to raise outvalid and latches their outputs.
- Serializes the latched outputs as a valid/ready stream to the next layer's sequencer.

---
 rtl/fnn_layer_seq.sv | 176 +++++++++++++++++
 tb/tb_fnn_layer_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnn_layer_seq.sv
// Per-layer sequencer: streams activations to the neurons, gathers
// their outputs and serializes them to the next layer.
module fnn_layer_seq #(
    parameter int numInputs  = 30,
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int maxWait    = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [dataWidth-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [dataWidth-1:0]            neuron_in,
    output logic                            neuron_in_valid,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    input  logic [numNeurons-1:0]           neuron_outvalid,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            layer_done,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int ICW = $clog2(numInputs + 1);
    localparam int IW  = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam int WCW = $clog2(maxWait + 1);

    localparam logic [ICW-1:0] IN_LAST   = ICW'(numInputs);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(numNeurons - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(maxWait - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [ICW-1:0]        in_cnt_q, in_cnt_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [numNeurons-1:0] done_q, done_d;
    logic [dataWidth-1:0]  cap_q [numNeurons];
    logic [dataWidth-1:0]  cap_d [numNeurons];
    logic [dataWidth-1:0]  nin_q, nin_d;
    logic                  nin_valid_q, nin_valid_d;
    logic [dataWidth-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  layer_done_q, layer_done_d;
    logic                  timeout_q, timeout_d;
    logic                  accept;

    assign in_ready = rst & ((state_q == S_IDLE) | (state_q == S_FEED));
    assign accept   = in_valid & in_ready;

    assign neuron_in       = nin_q;
    assign neuron_in_valid = nin_valid_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign layer_done      = layer_done_q;
    assign busy            = (state_q != S_IDLE);
    assign timeout_err     = timeout_q;

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        wait_cnt_d   = '0;
        idx_d        = idx_q;
        done_d       = done_q;
        cap_d        = cap_q;
        nin_d        = nin_q;
        nin_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        layer_done_d = 1'b0;
        timeout_d    = timeout_q;

        if (accept) begin
            nin_d       = in_data;
            nin_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    done_d   = '0;
                    in_cnt_d = ICW'(1);
                    state_d  = (numInputs == 1) ? S_WAIT : S_FEED;
                end
            end
            S_FEED: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_d == IN_LAST) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Timeout has priority; a pulse in the abort cycle is dropped
                if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    done_d    = '0;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    for (int k = 0; k < numNeurons; k++) begin
                        if (neuron_outvalid[k]) begin
                            cap_d[k]  = neuron_out[k*dataWidth +: dataWidth];
                            done_d[k] = 1'b1;
                        end
                    end
                    if (&done_d) begin
                        wait_cnt_d = '0;
                        idx_d      = '0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        layer_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_DRAIN);
        if (state_d == S_DRAIN) begin
            out_data_d = cap_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            idx_q        <= '0;
            done_q       <= '0;
            nin_q        <= '0;
            nin_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            layer_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            for (int k = 0; k < numNeurons; k++) begin
                cap_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
            nin_q        <= nin_d;
            nin_valid_q  <= nin_valid_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            layer_done_q <= layer_done_d;
            timeout_q    <= timeout_d;
            for (int k = 0; k < numNeurons; k++) begin
                cap_q[k] <= cap_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fnn_layer_seq.sv
// Scoreboard bench for fnn_layer_seq with 4 inputs, 3 neurons and a
// short WAIT limit.
module tb_fnn_layer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] neuron_in;
    logic        neuron_in_valid;
    logic [47:0] neuron_out = '0;
    logic [2:0]  neuron_outvalid = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        layer_done;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    logic [15:0] nin_q [$];
    logic [15:0] out_q [$];
    logic [15:0] exp_cap [3];

    fnn_layer_seq #(
        .numInputs (4),
        .numNeurons(3),
        .dataWidth (16),
        .maxWait   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .neuron_in      (neuron_in),
        .neuron_in_valid(neuron_in_valid),
        .neuron_out     (neuron_out),
        .neuron_outvalid(neuron_outvalid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .layer_done     (layer_done),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat j carries base + (j+1)*0x100; pat bit c is in_valid on cycle c
    task automatic feed(input logic [15:0] pat, input int plen, input logic [15:0] base);
        int j = 0;
        int nv = 0;
        logic acc;
        logic [15:0] e;
        for (int c = 0; c < plen; c++) begin
            checks++;
            if (in_ready !== (j < 4)) begin
                failures++;
                $display("FAIL feed_in_ready c=%0d got=%b exp=%b", c, in_ready, j < 4);
            end
            in_valid = pat[c];
            in_data  = base + 16'((j + 1) * 256);
            acc = in_valid && in_ready;
            if (acc) begin
                nin_q.push_back(in_data);
                j++;
            end
            tick();
            in_valid = 1'b0;
            checks++;
            if (neuron_in_valid !== acc) begin
                failures++;
                $display("FAIL feed_nin_valid c=%0d got=%b exp=%b", c, neuron_in_valid, acc);
            end
            if (neuron_in_valid === 1'b1) nv++;
            if (acc) begin
                e = nin_q.pop_front();
                checks++;
                if (neuron_in !== e) begin
                    failures++;
                    $display("FAIL feed_nin_data c=%0d got=%h exp=%h", c, neuron_in, e);
                end
            end
        end
        checks++;
        if (nv != 4) begin
            failures++;
            $display("FAIL feed_beats got=%0d exp=4", nv);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL feed_wait_state in_ready=%b busy=%b exp 0/1", in_ready, busy);
        end
    endtask

    task automatic pulse(input logic [2:0] m, input logic [15:0] v0,
                         input logic [15:0] v1, input logic [15:0] v2);
        logic [15:0] v [3];
        v[0] = v0;
        v[1] = v1;
        v[2] = v2;
        neuron_outvalid = m;
        neuron_out = {v2, v1, v0};
        for (int k = 0; k < 3; k++) begin
            if (m[k]) exp_cap[k] = v[k];
        end
        tick();
        neuron_outvalid = '0;
    endtask

    task automatic push_caps();
        for (int k = 0; k < 3; k++) out_q.push_back(exp_cap[k]);
    endtask

    // rdy bit (c % rlen) drives out_ready on drain cycle c
    task automatic drain(input logic [7:0] rdy, input int rlen);
        int c = 0;
        bit fin = 0;
        logic h;
        while (!fin && c < 40) begin
            out_ready = rdy[c % rlen];
            checks++;
            if (out_valid !== 1'b1 || out_data !== out_q[0]) begin
                failures++;
                $display("FAIL drain_out c=%0d valid=%b data=%h exp 1/%h",
                         c, out_valid, out_data, out_q[0]);
            end
            h = out_ready;
            tick();
            c++;
            if (h) void'(out_q.pop_front());
            if (out_q.size() == 0) begin
                fin = 1;
            end else begin
                checks++;
                if (layer_done !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_early_done c=%0d got=%b exp=0", c, layer_done);
                end
            end
        end
        out_ready = 1'b0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL drain_bound remaining=%0d exp=0", out_q.size());
        end
        checks++;
        if (layer_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_end done=%b busy=%b valid=%b exp 1/0/0",
                     layer_done, busy, out_valid);
        end
        tick();
        checks++;
        if (layer_done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_done_pulse done=%b in_ready=%b exp 0/1", layer_done, in_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b0 || neuron_in_valid !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || layer_done !== 1'b0 || timeout_err !== 1'b0 ||
            out_data !== 16'h0 || neuron_in !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b niv=%b ov=%b busy=%b ld=%b to=%b od=%h ni=%h exp all 0",
                     in_ready, neuron_in_valid, out_valid, busy, layer_done,
                     timeout_err, out_data, neuron_in);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_idle_pulse_ignored();
        pulse(3'b111, 16'h7777, 16'h7777, 16'h7777);
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_pulse busy=%b valid=%b exp 0/0", busy, out_valid);
        end
    endtask

    task automatic test_in_order();
        feed(16'h000F, 4, 16'h0000);
        pulse(3'b100, 16'h0, 16'h0, 16'h00AA);
        pulse(3'b001, 16'h0011, 16'h0, 16'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL partial_done out_valid got=%b exp=0", out_valid);
        end
        pulse(3'b010, 16'h0, 16'h0055, 16'h0);
        push_caps();
        drain(8'h01, 1);
    endtask

    task automatic test_stall();
        feed(16'h000F, 4, 16'h0010);
        pulse(3'b111, 16'h0011, 16'h0055, 16'h00AA);
        push_caps();
        drain(8'b0001_1001, 5);
    endtask

    task automatic test_gaps();
        feed(16'b0101_1001, 7, 16'h0003);
        pulse(3'b001, 16'h1234, 16'h0, 16'h0);
        pulse(3'b001, 16'h2222, 16'h0, 16'h0);
        pulse(3'b110, 16'h0, 16'hBEEF, 16'hC0DE);
        push_caps();
        drain(8'h01, 1);
    endtask

    task automatic test_timeout();
        feed(16'h000F, 4, 16'h0020);
        pulse(3'b001, 16'h0101, 16'h0, 16'h0);
        pulse(3'b010, 16'h0, 16'h0202, 16'h0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (timeout_err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL timeout_early i=%0d to=%b ov=%b busy=%b exp 0/0/1",
                         i, timeout_err, out_valid, busy);
            end
            tick();
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort to=%b busy=%b rdy=%b ov=%b exp 1/0/1/0",
                     timeout_err, busy, in_ready, out_valid);
        end
        feed(16'h000F, 4, 16'h0030);
        pulse(3'b111, 16'h0A0A, 16'h0B0B, 16'h0C0C);
        push_caps();
        drain(8'h01, 1);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_drain();
        feed(16'h000F, 4, 16'h0040);
        pulse(3'b111, 16'h1111, 16'h2222, 16'h3333);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_data !== 16'h2222 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_drain data=%h valid=%b exp 2222/1", out_data, out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 ||
            in_ready !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset ov=%b busy=%b od=%h rdy=%b to=%b exp 0/0/0/0/0",
                     out_valid, busy, out_data, in_ready, timeout_err);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_recover in_ready got=%b exp=1", in_ready);
        end
        out_q.delete();
        feed(16'h000F, 4, 16'h0050);
        pulse(3'b111, 16'h4444, 16'h5555, 16'h6666);
        push_caps();
        drain(8'h01, 1);
    endtask

    initial begin
        test_reset();
        test_idle_pulse_ignored();
        test_in_order();
        test_stall();
        test_gaps();
        test_timeout();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
